// File: rtl/issue_unit_pkg.sv
// Shared constants for the issue unit: default unit latencies, CDB
// reservation depth and the 2-bit encoding of the granted unit.
package issue_unit_pkg;

    localparam int INT_LAT_DEF    = 1;
    localparam int LS_LAT_DEF     = 1;
    localparam int MUL_LAT_DEF    = 4;
    localparam int DIV_LAT_DEF    = 7;
    localparam int SLOT_DEPTH_DEF = 7;
    localparam int NUM_UNITS      = 4;

    // Encoding doubles as the bit index of each unit in the grant vector.
    typedef enum logic [1:0] {
        UNIT_INT = 2'b00,
        UNIT_LS  = 2'b01,
        UNIT_MUL = 2'b10,
        UNIT_DIV = 2'b11
    } unit_e;

    // Width needed to carry a latency value 0..depth.
    function automatic int lat_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iu_cdb_slot_reg.sv
// CDB reservation shift register. Bit k set means the CDB is already
// claimed k+1 cycles from now. Queries report whether the CDB cycle a
// given latency would land on is free; a mark claims that cycle.
module iu_cdb_slot_reg
    import issue_unit_pkg::*;
#(
    parameter int SLOT_DEPTH = SLOT_DEPTH_DEF,
    parameter int LAT_W      = lat_width(SLOT_DEPTH_DEF),
    parameter int NQ         = NUM_UNITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NQ-1:0][LAT_W-1:0]   query_lat_i,
    output logic [NQ-1:0]              query_free_o,
    input  logic                       mark_en_i,
    input  logic [LAT_W-1:0]           mark_lat_i
);

    logic [SLOT_DEPTH-1:0] slot_q;
    logic [SLOT_DEPTH-1:0] slot_d;

    genvar gi;

    // One lookup per query port: latency L checks slot L-1.
    generate
        for (gi = 0; gi < NQ; gi++) begin : g_query
            logic free_b;
            // Select the slot bit matching this query's latency.
            always_comb begin
                free_b = 1'b1;
                for (int k = 0; k < SLOT_DEPTH; k++) begin
                    if (int'(query_lat_i[gi]) == k + 1) begin
                        free_b = ~slot_q[k];
                    end
                end
            end
            assign query_free_o[gi] = free_b;
        end
    endgenerate

    // Next state: shift toward slot 0 and add the new mark. The mark is
    // placed one position lower (L-2) because the register advances as it
    // is written. Latency-1 results never need a mark.
    generate
        for (gi = 0; gi < SLOT_DEPTH; gi++) begin : g_shift
            logic mark_hit;
            assign mark_hit = mark_en_i && (int'(mark_lat_i) == gi + 2);
            if (gi == SLOT_DEPTH - 1) begin : g_top
                assign slot_d[gi] = mark_hit;
            end else begin : g_mid
                assign slot_d[gi] = slot_q[gi+1] | mark_hit;
            end
        end
    endgenerate

    // Reservation register; reset discards all outstanding claims.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Single-issue scheduler: picks at most one ready issue queue per cycle,
// honouring CDB slot availability and divider occupancy.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int INT_LAT    = INT_LAT_DEF,
    parameter int LS_LAT     = LS_LAT_DEF,
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int DIV_LAT    = DIV_LAT_DEF,
    parameter int SLOT_DEPTH = SLOT_DEPTH_DEF  // must cover the largest latency
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iq_int_rdy,
    input  logic       iq_ls_rdy,
    input  logic       iq_mul_rdy,
    input  logic       iq_div_rdy,
    input  logic       cdb_flush,
    output logic       iu_int_r_en,
    output logic       iu_ls_r_en,
    output logic       iu_mul_r_en,
    output logic       iu_div_r_en,
    output logic       iu_issue_valid,
    output logic [1:0] iu_issue_unit,
    output logic       iu_div_busy
);

    localparam int LAT_W = lat_width(SLOT_DEPTH);
    localparam int CNT_W = lat_width(DIV_LAT);

    logic [NUM_UNITS-1:0][LAT_W-1:0] query_lat;
    logic [NUM_UNITS-1:0]            query_free;
    logic [CNT_W-1:0]                div_cnt_q, div_cnt_d;
    logic                            favor_ls_q, favor_ls_d;
    logic                            elig_int, elig_ls, elig_mul, elig_div;
    logic [NUM_UNITS-1:0]            grant;
    unit_e                           unit_sel;
    logic [LAT_W-1:0]                mark_lat;

    // Query ports indexed by unit encoding.
    assign query_lat[UNIT_INT] = LAT_W'(INT_LAT);
    assign query_lat[UNIT_LS]  = LAT_W'(LS_LAT);
    assign query_lat[UNIT_MUL] = LAT_W'(MUL_LAT);
    assign query_lat[UNIT_DIV] = LAT_W'(DIV_LAT);

    iu_cdb_slot_reg #(
        .SLOT_DEPTH (SLOT_DEPTH),
        .LAT_W      (LAT_W),
        .NQ         (NUM_UNITS)
    ) u_slots (
        .clk          (clk),
        .reset        (reset),
        .query_lat_i  (query_lat),
        .query_free_o (query_free),
        .mark_en_i    (iu_issue_valid),
        .mark_lat_i   (mark_lat)
    );

    assign elig_int = iq_int_rdy & query_free[UNIT_INT];
    assign elig_ls  = iq_ls_rdy  & query_free[UNIT_LS];
    assign elig_mul = iq_mul_rdy & query_free[UNIT_MUL];
    assign elig_div = iq_div_rdy & query_free[UNIT_DIV] & (div_cnt_q == '0);

    // Fixed priority div > mul, round-robin between int and ls; nothing
    // issues during reset or a flush cycle.
    always_comb begin
        grant    = '0;
        unit_sel = UNIT_INT;
        if (!(reset || cdb_flush)) begin
            if (elig_div) begin
                unit_sel = UNIT_DIV;
            end else if (elig_mul) begin
                unit_sel = UNIT_MUL;
            end else if (elig_int && elig_ls) begin
                unit_sel = favor_ls_q ? UNIT_LS : UNIT_INT;
            end else if (elig_ls) begin
                unit_sel = UNIT_LS;
            end else begin
                unit_sel = UNIT_INT;
            end
            if (elig_div || elig_mul || elig_int || elig_ls) begin
                grant[unit_sel] = 1'b1;
            end
        end
    end

    // Latency of the granted unit, used to claim its CDB cycle.
    always_comb begin
        mark_lat = '0;
        case (unit_sel)
            UNIT_INT: mark_lat = LAT_W'(INT_LAT);
            UNIT_LS:  mark_lat = LAT_W'(LS_LAT);
            UNIT_MUL: mark_lat = LAT_W'(MUL_LAT);
            UNIT_DIV: mark_lat = LAT_W'(DIV_LAT);
            default:  mark_lat = '0;
        endcase
    end

    assign iu_int_r_en    = grant[UNIT_INT];
    assign iu_ls_r_en     = grant[UNIT_LS];
    assign iu_mul_r_en    = grant[UNIT_MUL];
    assign iu_div_r_en    = grant[UNIT_DIV];
    assign iu_issue_valid = |grant;
    assign iu_issue_unit  = iu_issue_valid ? unit_sel : UNIT_INT;
    assign iu_div_busy    = (div_cnt_q != '0) & ~reset;

    // Divider occupancy countdown and int/ls fairness pointer next state.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        favor_ls_d = favor_ls_q;
        if (grant[UNIT_DIV]) begin
            div_cnt_d = CNT_W'(DIV_LAT - 1);
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
        if (grant[UNIT_INT]) begin
            favor_ls_d = 1'b1;
        end else if (grant[UNIT_LS]) begin
            favor_ls_d = 1'b0;
        end
    end

    // Scheduler state; flush leaves it alone, reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            favor_ls_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            favor_ls_q <= favor_ls_d;
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Testbench for issue_unit: a directed vector table with hand-derived
// expectations, followed by random traffic checked against an absolute-time
// CDB booking model. Expected results flow through a scoreboard queue.
module tb_issue_unit;
    import issue_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       iq_int_rdy, iq_ls_rdy, iq_mul_rdy, iq_div_rdy;
    logic       cdb_flush;
    logic       iu_int_r_en, iu_ls_r_en, iu_mul_r_en, iu_div_r_en;
    logic       iu_issue_valid;
    logic [1:0] iu_issue_unit;
    logic       iu_div_busy;

    always #5 clk = ~clk;

    issue_unit dut (
        .clk            (clk),
        .reset          (reset),
        .iq_int_rdy     (iq_int_rdy),
        .iq_ls_rdy      (iq_ls_rdy),
        .iq_mul_rdy     (iq_mul_rdy),
        .iq_div_rdy     (iq_div_rdy),
        .cdb_flush      (cdb_flush),
        .iu_int_r_en    (iu_int_r_en),
        .iu_ls_r_en     (iu_ls_r_en),
        .iu_mul_r_en    (iu_mul_r_en),
        .iu_div_r_en    (iu_div_r_en),
        .iu_issue_valid (iu_issue_valid),
        .iu_issue_unit  (iu_issue_unit),
        .iu_div_busy    (iu_div_busy)
    );

    // rdy is {div, mul, ls, int}
    typedef struct packed {
        logic       rst;
        logic       flush;
        logic [3:0] rdy;
        logic       valid;
        logic [1:0] unit;
        logic       busy;
    } vec_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] unit;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   txn      = 0;

    // Reference model: CDB bookings by absolute cycle number.
    bit   res_m[int];
    int   cyc_m;
    int   div_free_m;
    bit   favor_m;

    function automatic vec_t v(input logic rst, input logic flush, input logic [3:0] rdy,
                               input logic valid, input logic [1:0] unit, input logic busy);
        vec_t r;
        r.rst = rst; r.flush = flush; r.rdy = rdy;
        r.valid = valid; r.unit = unit; r.busy = busy;
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic flush, input logic [3:0] rdy,
                              output exp_t e);
        bit ei, el, em, ed;
        e = '0;
        if (rst) begin
            res_m.delete();
            div_free_m = 0;
            favor_m    = 1'b0;
        end else begin
            e.busy = (cyc_m < div_free_m);
            ei = rdy[0] && !res_m.exists(cyc_m + INT_LAT_DEF);
            el = rdy[1] && !res_m.exists(cyc_m + LS_LAT_DEF);
            em = rdy[2] && !res_m.exists(cyc_m + MUL_LAT_DEF);
            ed = rdy[3] && !res_m.exists(cyc_m + DIV_LAT_DEF) && (cyc_m >= div_free_m);
            if (!flush) begin
                if (ed) begin
                    e.valid = 1'b1; e.unit = 2'd3;
                    res_m[cyc_m + DIV_LAT_DEF] = 1'b1;
                    div_free_m = cyc_m + DIV_LAT_DEF;
                end else if (em) begin
                    e.valid = 1'b1; e.unit = 2'd2;
                    res_m[cyc_m + MUL_LAT_DEF] = 1'b1;
                end else if (ei && (!el || !favor_m)) begin
                    e.valid = 1'b1; e.unit = 2'd0;
                    res_m[cyc_m + INT_LAT_DEF] = 1'b1;
                    favor_m = 1'b1;
                end else if (el) begin
                    e.valid = 1'b1; e.unit = 2'd1;
                    res_m[cyc_m + LS_LAT_DEF] = 1'b1;
                    favor_m = 1'b0;
                end
            end
        end
        cyc_m++;
    endtask

    // Drive one cycle, queue its expectation, then check the settled outputs.
    task automatic run_cycle(input string tag, input logic rst, input logic flush,
                             input logic [3:0] rdy, input exp_t e);
        exp_t       x;
        logic [3:0] exp_en;
        logic [3:0] got_en;
        logic [7:0] got_v, exp_v;
        @(posedge clk);
        #1;
        reset      = rst;
        cdb_flush  = flush;
        iq_int_rdy = rdy[0];
        iq_ls_rdy  = rdy[1];
        iq_mul_rdy = rdy[2];
        iq_div_rdy = rdy[3];
        sb_q.push_back(e);
        @(negedge clk);
        got_en = {iu_div_r_en, iu_mul_r_en, iu_ls_r_en, iu_int_r_en};
        got_v  = {got_en, iu_issue_valid, iu_issue_unit, iu_div_busy};
        chk_cnt++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s #%0d: scoreboard empty, got %b required an entry", tag, txn, got_v);
        end else begin
            x = sb_q.pop_front();
            exp_en = '0;
            if (x.valid) exp_en[x.unit] = 1'b1;
            exp_v = {exp_en, x.valid, x.unit, x.busy};
            if (got_v === exp_v) begin
                pass_cnt++;
                $display("%s #%0d rst=%0b fl=%0b rdy=%b en=%b v=%0b u=%0d busy=%0b ok",
                         tag, txn, rst, flush, rdy, got_en, iu_issue_valid,
                         iu_issue_unit, iu_div_busy);
            end else begin
                $display("FAIL %s #%0d rst=%0b fl=%0b rdy=%b got en/v/u/busy=%b required %b",
                         tag, txn, rst, flush, rdy, got_v, exp_v);
            end
        end
        txn++;
    endtask

    initial begin
        exp_t e;
        logic r, f;
        logic [3:0] rd;

        reset = 1'b1; cdb_flush = 1'b0;
        iq_int_rdy = 1'b0; iq_ls_rdy = 1'b0; iq_mul_rdy = 1'b0; iq_div_rdy = 1'b0;

        //           rst fl rdy  v  u  busy
        tbl.push_back(v(1, 0, 4'hF, 0, 0, 0)); // reset cycle: all quiet
        tbl.push_back(v(0, 0, 4'hF, 1, 3, 0)); // div wins
        tbl.push_back(v(0, 0, 4'hF, 1, 2, 1)); // mul next, divider busy
        tbl.push_back(v(0, 0, 4'h0, 0, 0, 1));
        tbl.push_back(v(1, 0, 4'h0, 0, 0, 0)); // reset with div_cnt=4, slots booked
        tbl.push_back(v(0, 0, 4'h1, 1, 0, 0)); // old mul slot gone: int issues
        tbl.push_back(v(0, 0, 4'h8, 1, 3, 0)); // divider free again
        tbl.push_back(v(1, 0, 4'h0, 0, 0, 0)); // reset clears favor_ls
        tbl.push_back(v(0, 0, 4'h3, 1, 0, 0)); // int/ls alternate, int first
        tbl.push_back(v(0, 0, 4'h3, 1, 1, 0));
        tbl.push_back(v(0, 0, 4'h3, 1, 0, 0));
        tbl.push_back(v(0, 0, 4'h3, 1, 1, 0));
        tbl.push_back(v(0, 0, 4'h4, 1, 2, 0)); // mul at t0
        tbl.push_back(v(0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'h1, 0, 0, 0)); // int blocked at t0+3
        tbl.push_back(v(0, 0, 4'h1, 1, 0, 0)); // int at t0+4
        tbl.push_back(v(0, 0, 4'h8, 1, 3, 0)); // div at t1
        tbl.push_back(v(0, 0, 4'h0, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'h0, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'h4, 0, 0, 1)); // mul blocked at t1+3
        tbl.push_back(v(0, 0, 4'h4, 1, 2, 1)); // mul at t1+4
        tbl.push_back(v(0, 0, 4'h8, 0, 0, 1)); // div still occupied
        tbl.push_back(v(0, 0, 4'h8, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'h8, 1, 3, 0)); // div again at t1+7
        tbl.push_back(v(0, 0, 4'h4, 1, 2, 1)); // mul books CDB 4 ahead
        tbl.push_back(v(0, 1, 4'h1, 0, 0, 1)); // flush suppresses int
        tbl.push_back(v(0, 0, 4'h1, 1, 0, 1));
        tbl.push_back(v(0, 0, 4'h1, 0, 0, 1)); // mul booking survived flush
        tbl.push_back(v(0, 0, 4'h1, 1, 0, 1));
        tbl.push_back(v(0, 0, 4'h1, 0, 0, 1)); // div booking blocks int
        tbl.push_back(v(0, 0, 4'h1, 1, 0, 0));
        tbl.push_back(v(0, 0, 4'h3, 1, 1, 0)); // favor_ls after int
        tbl.push_back(v(0, 0, 4'h3, 1, 0, 0));
        tbl.push_back(v(0, 1, 4'h8, 0, 0, 0)); // flush suppresses div
        tbl.push_back(v(0, 0, 4'h8, 1, 3, 0));

        foreach (tbl[i]) begin
            e.valid = tbl[i].valid;
            e.unit  = tbl[i].unit;
            e.busy  = tbl[i].busy;
            run_cycle("vec", tbl[i].rst, tbl[i].flush, tbl[i].rdy, e);
        end

        cyc_m = 0; div_free_m = 0; favor_m = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r  = (i == 0) || ($urandom_range(0, 63) == 0);
            f  = ($urandom_range(0, 15) == 0);
            rd = 4'($urandom_range(0, 15));
            model_step(r, f, rd, e);
            run_cycle("rnd", r, f, rd, e);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
